// File: rtl/bcd_entry_cgrundey.sv
// Two-digit decimal keypad entry (00-39) feeding an active-low-enabled BCD-to-binary converter.
// Optional feature: define BCD_ENTRY_BACKSPACE_EN to make key code 4'hC a backspace.
module bcd_entry_cgrundey #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_code,
  output logic       g_n,
  output logic [5:0] bcd_out,
  output logic [1:0] digit_cnt,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
`ifdef BCD_ENTRY_BACKSPACE_EN
  localparam logic [3:0] KEY_BS  = 4'hC;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ONE    = 3'd1,
    S_TWO    = 3'd2,
    S_SETTLE = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             g_n_q, g_n_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] settle_q, settle_d;

  logic accept;
  logic is_digit;
  logic is_bs;

  assign key_ready = (state_q != S_SETTLE);
  assign accept    = key_valid && key_ready;
  assign is_digit  = (key_code <= 4'd9);
`ifdef BCD_ENTRY_BACKSPACE_EN
  assign is_bs     = (key_code == KEY_BS);
`else
  assign is_bs     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tens_q   <= '0;
      ones_q   <= '0;
      cnt_q    <= '0;
      g_n_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      cnt_q    <= cnt_d;
      g_n_q    <= g_n_d;
      done_q   <= done_d;
      err_q    <= err_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_SETTLE) begin
      if (settle_q == '0) state_d = S_SHOW;
    end else if (accept) begin
      if (is_digit) begin
        case (state_q)
          S_IDLE, S_SHOW: state_d = S_ONE;
          S_ONE:          state_d = (ones_q > 4'd3) ? S_ONE : S_TWO;
          default:        state_d = state_q;
        endcase
      end else if (key_code == KEY_CLR) begin
        state_d = S_IDLE;
      end else if (key_code == KEY_ENT) begin
        if (state_q == S_ONE || state_q == S_TWO) state_d = S_SETTLE;
      end else if (is_bs) begin
        // In SHOW the held digit count decides which step back applies
        case (state_q)
          S_TWO:   state_d = S_ONE;
          S_ONE:   state_d = S_IDLE;
          S_SHOW:  state_d = (cnt_q == 2'd2) ? S_ONE : S_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    tens_d   = tens_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;
    g_n_d    = g_n_q;
    done_d   = done_q;
    err_d    = 1'b0;
    settle_d = settle_q;
    if (state_q == S_SETTLE) begin
      if (settle_q == '0) done_d = 1'b1;
      else                settle_d = settle_q - CNT_W'(1);
    end else if (accept) begin
      if (is_digit) begin
        case (state_q)
          S_IDLE, S_SHOW: begin
            tens_d = 2'd0;
            ones_d = key_code;
            cnt_d  = 2'd1;
            g_n_d  = 1'b1;
            done_d = 1'b0;
          end
          S_ONE: begin
            // A leading digit above 3 would push the value past 39
            if (ones_q > 4'd3) begin
              err_d = 1'b1;
            end else begin
              tens_d = ones_q[1:0];
              ones_d = key_code;
              cnt_d  = 2'd2;
            end
          end
          default: err_d = 1'b1;
        endcase
      end else if (key_code == KEY_CLR) begin
        tens_d = 2'd0;
        ones_d = 4'd0;
        cnt_d  = 2'd0;
        g_n_d  = 1'b1;
        done_d = 1'b0;
      end else if (key_code == KEY_ENT) begin
        case (state_q)
          S_IDLE: err_d = 1'b1;
          S_ONE, S_TWO: begin
            g_n_d    = 1'b0;
            settle_d = CNT_W'(SETTLE_CYCLES - 1);
          end
          default: ;
        endcase
      end else if (is_bs) begin
        if (state_q == S_IDLE) begin
          err_d = 1'b1;
        end else if (state_q == S_TWO || (state_q == S_SHOW && cnt_q == 2'd2)) begin
          ones_d = {2'b00, tens_q};
          tens_d = 2'd0;
          cnt_d  = 2'd1;
          g_n_d  = 1'b1;
          done_d = 1'b0;
        end else begin
          ones_d = 4'd0;
          tens_d = 2'd0;
          cnt_d  = 2'd0;
          g_n_d  = 1'b1;
          done_d = 1'b0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign g_n       = g_n_q;
  assign bcd_out   = {tens_q, ones_q};
  assign digit_cnt = cnt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
